// File: rtl/spi_tx_framer.sv
// ---------------------------------------------------------------------------
// spi_tx_framer
//
// Buffers 16-bit words from a Cypress slave-FIFO reader and serialises them
// MSB first onto a simple SPI-style link. Words are grouped into messages.
// The first word of a message is a header whose low byte gives the total
// word count, including the header. A low byte of zero counts as one word.
//
// Parameters
//   CLK_DIV  system clock cycles per serial bit period (even, >= 2)
//   FIFO_AW  word FIFO address width, depth D = 2**FIFO_AW (>= 2)
//
// Ports
//   CLK       in   system clock, all logic on the rising edge
//   RST       in   synchronous active-high reset
//   DATA      in   16-bit word from the reader
//   ENA       in   one-cycle write strobe for DATA
//   BUSY      out  back-pressure, high once the FIFO holds D-2 or more words
//   TX_SCLK   out  serial clock, low for the first half of each bit period
//   TX_DATA   out  serial data, MSB first
//   TX_LOAD   out  high for the whole of bit 0 of every word
//   TX_STOP   out  high for the whole of bit 0 of the last word of a message
//   MSG_DONE  out  one-cycle pulse on the last cycle of the post-message gap
//   ERR_OVF   out  sticky overflow flag, cleared only by RST
// ---------------------------------------------------------------------------
module spi_tx_framer #(
    parameter int CLK_DIV = 4,
    parameter int FIFO_AW = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] DATA,
    input  logic        ENA,
    output logic        BUSY,
    output logic        TX_SCLK,
    output logic        TX_DATA,
    output logic        TX_LOAD,
    output logic        TX_STOP,
    output logic        MSG_DONE,
    output logic        ERR_OVF
);

    localparam int D  = 2 ** FIFO_AW;
    // One counter serves both the bit period and the 2*CLK_DIV gap.
    localparam int CW = $clog2(2 * CLK_DIV);

    localparam logic [CW-1:0]      CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]      CNT_HALF  = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0]      CNT_BIT   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]      CNT_GAP   = CW'(2 * CLK_DIV - 1);
    localparam logic [FIFO_AW:0]   FILL_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   FILL_FULL = (FIFO_AW + 1)'(D);
    localparam logic [FIFO_AW:0]   FILL_BUSY = (FIFO_AW + 1)'(D - 2);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [15:0]        mem_q [D];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q,  count_d;
    logic               push_s;
    logic               pop_s;
    logic               empty_s;
    logic [15:0]        head_s;

    // Framer state
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q,   cnt_d;
    logic [3:0]         bit_q,   bit_d;
    logic [7:0]         rem_q,   rem_d;
    logic [15:0]        shift_q, shift_d;

    // Registered outputs
    logic busy_q,     busy_d;
    logic tx_sclk_q,  tx_sclk_d;
    logic tx_data_q,  tx_data_d;
    logic tx_load_q,  tx_load_d;
    logic tx_stop_q,  tx_stop_d;
    logic msg_done_q, msg_done_d;
    logic err_ovf_q,  err_ovf_d;

    assign empty_s = (count_q == {(FIFO_AW + 1){1'b0}});
    assign head_s  = mem_q[rd_ptr_q];

    // FIFO next state: a full FIFO still accepts a word when a pop frees a slot
    always_comb begin
        push_s    = ENA && ((count_q != FILL_FULL) || pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_ovf_d = err_ovf_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + FILL_ONE;
            2'b01:   count_d = count_q - FILL_ONE;
            default: count_d = count_q;
        endcase
        if (ENA && !push_s) begin
            err_ovf_d = 1'b1;
        end else begin
            err_ovf_d = err_ovf_q;
        end
        // Evaluated on the next fill level so BUSY is already high when the
        // count reaches D-2.
        busy_d = (count_d >= FILL_BUSY);
    end

    // FIFO word storage, no reset needed since the pointers define validity
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= DATA;
        end
    end

    // Framer next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        rem_d   = rem_q;
        shift_d = shift_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = head_s;
                    rem_d   = (head_s[7:0] == 8'd0) ? 8'd1 : head_s[7:0];
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                bit_d   = 4'd15;
                cnt_d   = CNT_ZERO;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_BIT) begin
                    cnt_d = CNT_ZERO;
                    if (bit_q == 4'd0) begin
                        rem_d = rem_q - 8'd1;
                        // The pop for the next word happens in the WAIT cycle,
                        // which gives the two-cycle inter-word spacing.
                        if (rem_q == 8'd1) begin
                            state_d = ST_GAP;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end else begin
                        bit_d = bit_q - 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = head_s;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_GAP) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next framer state
    always_comb begin
        tx_sclk_d  = (state_d == ST_SHIFT) && (cnt_d >= CNT_HALF);
        tx_load_d  = (state_d == ST_SHIFT) && (bit_d == 4'd0);
        tx_stop_d  = tx_load_d && (rem_d == 8'd1);
        msg_done_d = (state_d == ST_GAP) && (cnt_d == CNT_GAP);
        tx_data_d  = tx_data_q;
        if ((state_d == ST_IDLE) || (state_d == ST_GAP)) begin
            tx_data_d = 1'b0;
        end else if ((state_d == ST_SHIFT) && (cnt_d == CNT_ZERO)) begin
            tx_data_d = shift_d[bit_d];
        end else begin
            // LOAD and WAIT keep the last bit on the line
            tx_data_d = tx_data_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q   <= {FIFO_AW{1'b0}};
            rd_ptr_q   <= {FIFO_AW{1'b0}};
            count_q    <= {(FIFO_AW + 1){1'b0}};
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_ZERO;
            bit_q      <= 4'd0;
            rem_q      <= 8'd0;
            shift_q    <= 16'd0;
            busy_q     <= 1'b0;
            tx_sclk_q  <= 1'b0;
            tx_data_q  <= 1'b0;
            tx_load_q  <= 1'b0;
            tx_stop_q  <= 1'b0;
            msg_done_q <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            rem_q      <= rem_d;
            shift_q    <= shift_d;
            busy_q     <= busy_d;
            tx_sclk_q  <= tx_sclk_d;
            tx_data_q  <= tx_data_d;
            tx_load_q  <= tx_load_d;
            tx_stop_q  <= tx_stop_d;
            msg_done_q <= msg_done_d;
            err_ovf_q  <= err_ovf_d;
        end
    end

    assign BUSY     = busy_q;
    assign TX_SCLK  = tx_sclk_q;
    assign TX_DATA  = tx_data_q;
    assign TX_LOAD  = tx_load_q;
    assign TX_STOP  = tx_stop_q;
    assign MSG_DONE = msg_done_q;
    assign ERR_OVF  = err_ovf_q;

endmodule

// File: tb/tb_spi_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_spi_tx_framer
//
// Directed bench for spi_tx_framer with CLK_DIV=4, FIFO_AW=3 (D=8).
// A negedge monitor records every TX_SCLK rising edge (data, load, stop,
// cycle) and every MSG_DONE cycle. Directed messages are then checked
// against hand-computed words, flag masks, spacings and latencies.
// ---------------------------------------------------------------------------
module tb_spi_tx_framer;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] DATA;
    logic        ENA;
    logic        BUSY, TX_SCLK, TX_DATA, TX_LOAD, TX_STOP, MSG_DONE, ERR_OVF;

    spi_tx_framer #(.CLK_DIV(4), .FIFO_AW(3)) dut (
        .CLK(CLK), .RST(RST), .DATA(DATA), .ENA(ENA), .BUSY(BUSY),
        .TX_SCLK(TX_SCLK), .TX_DATA(TX_DATA), .TX_LOAD(TX_LOAD),
        .TX_STOP(TX_STOP), .MSG_DONE(MSG_DONE), .ERR_OVF(ERR_OVF)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Serial-link monitor
    typedef struct {
        logic d;
        logic l;
        logic s;
        int   t;
    } rise_t;

    rise_t rises[$];
    int    done_t[$];
    int    hold_viol = 0;
    logic  prev_sclk = 1'b0;
    logic  prev_data = 1'b0;

    always @(negedge CLK) begin
        if (TX_SCLK && !prev_sclk) rises.push_back('{TX_DATA, TX_LOAD, TX_STOP, cyc});
        if (TX_SCLK && prev_sclk && (TX_DATA !== prev_data)) hold_viol <= hold_viol + 1;
        if (MSG_DONE) done_t.push_back(cyc);
        prev_sclk <= TX_SCLK;
        prev_data <= TX_DATA;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic write_word(input logic [15:0] w);
        DATA = w;
        ENA  = 1'b1;
        tick(1);
        ENA  = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n = 0;
        while (done_t.size() < target && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, 64'(done_t.size() >= target), 64'd1);
    endtask

    task automatic wait_rises(input int target, input int budget, input string tag);
        int n = 0;
        while (rises.size() < target && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, 64'(rises.size() >= target), 64'd1);
    endtask

    function automatic logic [15:0] word_at(input int base, input int w);
        logic [15:0] r = 16'd0;
        for (int j = 0; j < 16; j++) begin
            int idx = base + 16 * w + j;
            r = {r[14:0], (idx < rises.size()) ? rises[idx].d : 1'b0};
        end
        return r;
    endfunction

    function automatic logic [63:0] mask_of(input int base, input int n, input bit stop);
        logic [63:0] m = 64'd0;
        for (int i = base; i < base + n && i < rises.size(); i++)
            m = {m[62:0], stop ? rises[i].s : rises[i].l};
        return m;
    endfunction

    // Counts rise-to-rise spacings that differ from 4 inside a word or from
    // bgap across a word boundary (bgap=0 skips boundaries).
    function automatic int bad_spacing(input int base, input int n, input int bgap);
        int bad = 0;
        for (int i = base + 1; i < base + n && i < rises.size(); i++) begin
            int sp = rises[i].t - rises[i-1].t;
            if ((i - base) % 16 == 0) begin
                if (bgap != 0 && sp != bgap) bad++;
            end else if (sp != 4) begin
                bad++;
            end
        end
        return bad;
    endfunction

    function automatic logic [6:0] outs();
        return {BUSY, TX_SCLK, TX_DATA, TX_LOAD, TX_STOP, MSG_DONE, ERR_OVF};
    endfunction

    initial begin
        int base, dbase, k, k2, hi, bad;
        RST = 1'b1; ENA = 1'b0; DATA = 16'd0;
        tick(3);
        chk("reset_outs", 64'(outs()), 64'd0);
        RST = 1'b0;
        tick(2);

        // Single word 0x0001
        base = rises.size(); dbase = done_t.size(); k = cyc;
        write_word(16'h0001);
        wait_done(dbase + 1, 300, "t1_done_seen");
        chk("t1_nbits",   64'(rises.size() - base), 64'd16);
        chk("t1_word",    64'(word_at(base, 0)), 64'h0001);
        chk("t1_first",   64'(rises[base].t - k), 64'd5);
        chk("t1_load",    mask_of(base, 16, 1'b0), 64'h0001);
        chk("t1_stop",    mask_of(base, 16, 1'b1), 64'h0001);
        chk("t1_spacing", 64'(bad_spacing(base, 16, 6)), 64'd0);
        chk("t1_done_lat", 64'(done_t[dbase] - rises[base + 15].t), 64'd9);
        tick(3);
        chk("t1_done_cnt", 64'(done_t.size() - dbase), 64'd1);
        chk("t1_idle", 64'({TX_SCLK, TX_DATA, TX_LOAD, TX_STOP}), 64'd0);

        // Three-word message written back-to-back
        base = rises.size(); dbase = done_t.size();
        write_word(16'h0003); write_word(16'hA5A5); write_word(16'h5A5A);
        wait_done(dbase + 1, 500, "t2_done_seen");
        chk("t2_nbits", 64'(rises.size() - base), 64'd48);
        chk("t2_w0", 64'(word_at(base, 0)), 64'h0003);
        chk("t2_w1", 64'(word_at(base, 1)), 64'hA5A5);
        chk("t2_w2", 64'(word_at(base, 2)), 64'h5A5A);
        chk("t2_load", mask_of(base, 48, 1'b0), 64'h0000_0001_0001_0001);
        chk("t2_stop", mask_of(base, 48, 1'b1), 64'h0000_0000_0000_0001);
        chk("t2_spacing", 64'(bad_spacing(base, 48, 6)), 64'd0);

        // Header then payload delayed 40 cycles after the header finishes
        base = rises.size(); dbase = done_t.size();
        write_word(16'h0002);
        wait_rises(base + 16, 300, "t3_hdr_seen");
        tick(1);
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (TX_SCLK || TX_LOAD || TX_STOP) hi++;
        end
        chk("t3_wait_quiet", 64'(hi), 64'd0);
        chk("t3_wait_nbits", 64'(rises.size() - base), 64'd16);
        k2 = cyc;
        write_word(16'h1234);
        wait_done(dbase + 1, 300, "t3_done_seen");
        chk("t3_w1",     64'(word_at(base, 1)), 64'h1234);
        chk("t3_resume", 64'(rises[base + 16].t - k2), 64'd5);
        chk("t3_load",   mask_of(base, 32, 1'b0), 64'h0001_0001);
        chk("t3_stop",   mask_of(base, 32, 1'b1), 64'h0000_0001);
        chk("t3_spacing", 64'(bad_spacing(base, 32, 0)), 64'd0);

        // Header 0x0000 behaves as a one-word message
        base = rises.size(); dbase = done_t.size();
        write_word(16'h0000);
        wait_done(dbase + 1, 300, "t4_done_seen");
        tick(2);
        chk("t4_nbits", 64'(rises.size() - base), 64'd16);
        chk("t4_word",  64'(word_at(base, 0)), 64'h0000);
        chk("t4_stop",  mask_of(base, 16, 1'b1), 64'h0001);
        chk("t4_done_cnt", 64'(done_t.size() - dbase), 64'd1);

        // Overflow: D+1 writes while the header word is still shifting out
        base = rises.size(); dbase = done_t.size();
        write_word(16'h0009);
        tick(4);
        chk("t5_busy_empty", 64'(BUSY), 64'd0);
        for (int i = 0; i < 9; i++) begin
            if (i == 5) chk("t5_busy_at5", 64'(BUSY), 64'd0);
            if (i == 6) chk("t5_busy_at6", 64'(BUSY), 64'd1);
            if (i == 8) chk("t5_ovf_before", 64'(ERR_OVF), 64'd0);
            write_word(16'h1000 + 16'(i));
        end
        chk("t5_ovf_set", 64'(ERR_OVF), 64'd1);
        wait_done(dbase + 1, 2000, "t5_done_seen");
        chk("t5_nbits", 64'(rises.size() - base), 64'd144);
        bad = 0;
        for (int w = 1; w < 9; w++)
            if (word_at(base, w) !== 16'h1000 + 16'(w - 1)) bad++;
        chk("t5_payload", 64'(bad), 64'd0);
        chk("t5_stop", mask_of(base + 128, 16, 1'b1), 64'h0001);
        tick(5);
        chk("t5_ovf_sticky", 64'(ERR_OVF), 64'd1);
        chk("t5_busy_drained", 64'(BUSY), 64'd0);

        // Reset during bit 7 of the second word
        base = rises.size(); dbase = done_t.size();
        write_word(16'h0003); write_word(16'hAAAA); write_word(16'hBBBB);
        wait_rises(base + 25, 400, "t6_bit7_seen");
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        chk("t6_outs_zero", 64'(outs()), 64'd0);
        base = rises.size();
        tick(40);
        chk("t6_no_sclk", 64'(rises.size() - base), 64'd0);
        chk("t6_no_done", 64'(done_t.size() - dbase), 64'd0);
        write_word(16'h0001);
        wait_done(dbase + 1, 300, "t6_done_seen");
        chk("t6_nbits", 64'(rises.size() - base), 64'd16);
        chk("t6_word",  64'(word_at(base, 0)), 64'h0001);
        chk("t6_stop",  mask_of(base, 16, 1'b1), 64'h0001);

        chk("data_hold", 64'(hold_viol), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
